// File: rtl/dispensador_bebidas.sv
// Drink dispenser controller.
//
// Accepts coins of 100 and 500 into a saturating credit register, prices the
// selected drink, and then runs three timed stages (water, mix, serve). Any
// credit left over is returned as change when the sale completes.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   suma100       coin level, high while the last coin was 100
//   suma500       coin level, high while the last coin was 500
//   enable        selection level, high once a drink has been chosen
//   sel[2:0]      drink code, sampled only in CHECK
//   credito[11:0] accumulated credit
//   vuelto[11:0]  change returned by the last completed sale
//   valvula_agua  water valve, high during AGUA
//   mezclador     mixer, high during MEZCLA
//   servir        serve actuator, high during SERVIR
//   listo         one-cycle pulse at sale completion
//   rechazo       one-cycle pulse when a request is denied
//   estado[2:0]   current state code, for debug
//
// state  | meaning
// IDLE   | accept coins and wait for an enable edge
// CHECK  | price the selection against the credit (1 cycle)
// AGUA   | water valve open, T_ETAPA cycles
// MEZCLA | mixer running, T_ETAPA cycles
// SERVIR | serving, T_ETAPA cycles
// DONE   | pay out change, clear credit, pulse listo (1 cycle)
// DENY   | pulse rechazo, credit kept (1 cycle)

module dispensador_bebidas #(
  parameter int T_ETAPA     = 8,
  parameter int CREDITO_MAX = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        suma100,
  input  logic        suma500,
  input  logic        enable,
  input  logic [2:0]  sel,
  output logic [11:0] credito,
  output logic [11:0] vuelto,
  output logic        valvula_agua,
  output logic        mezclador,
  output logic        servir,
  output logic        listo,
  output logic        rechazo,
  output logic [2:0]  estado
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    AGUA   = 3'd2,
    MEZCLA = 3'd3,
    SERVIR = 3'd4,
    DONE   = 3'd5,
    DENY   = 3'd6
  } state_t;

  // Each stage lasts T_ETAPA cycles: load T_ETAPA-1, leave on terminal count 0.
  localparam logic [7:0]  T_LOAD = 8'(T_ETAPA - 1);
  localparam logic [11:0] C_MAX  = 12'(CREDITO_MAX);

  state_t      state, state_nxt;
  logic [11:0] credito_nxt, vuelto_nxt;
  logic [7:0]  cnt, cnt_nxt;

  logic        suma100_q, suma500_q, enable_q;
  logic        ed100, ed500, ed_en;

  logic [11:0] precio;
  logic        precio_ok;
  logic [12:0] add;
  logic [12:0] suma;

  assign ed100 = suma100 & ~suma100_q;
  assign ed500 = suma500 & ~suma500_q;
  assign ed_en = enable  & ~enable_q;

  always_comb begin
    precio    = 12'd0;
    precio_ok = 1'b1;
    case (sel)
      3'b001:  precio = 12'd300;
      3'b010:  precio = 12'd200;
      3'b011:  precio = 12'd500;
      3'b100:  precio = 12'd700;
      default: precio_ok = 1'b0;
    endcase
  end

  // One extra bit so the sum cannot wrap before the saturation compare.
  always_comb begin
    add = 13'd0;
    if (ed100) add = add + 13'd100;
    if (ed500) add = add + 13'd500;
    suma = {1'b0, credito} + add;
  end

  always_comb begin
    state_nxt   = state;
    credito_nxt = credito;
    vuelto_nxt  = vuelto;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        // Coin is credited in the same cycle an enable edge moves us to CHECK.
        if (ed100 | ed500) begin
          credito_nxt = (suma > {1'b0, C_MAX}) ? C_MAX : suma[11:0];
          vuelto_nxt  = 12'd0;
        end
        if (ed_en) state_nxt = CHECK;
      end
      CHECK: begin
        if (!precio_ok || (credito < precio)) begin
          state_nxt = DENY;
        end else begin
          credito_nxt = credito - precio;
          cnt_nxt     = T_LOAD;
          state_nxt   = AGUA;
        end
      end
      AGUA: begin
        if (cnt == 8'd0) begin
          cnt_nxt   = T_LOAD;
          state_nxt = MEZCLA;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      MEZCLA: begin
        if (cnt == 8'd0) begin
          cnt_nxt   = T_LOAD;
          state_nxt = SERVIR;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      SERVIR: begin
        if (cnt == 8'd0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DONE: begin
        vuelto_nxt  = credito;
        credito_nxt = 12'd0;
        state_nxt   = IDLE;
      end
      DENY: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      credito   <= 12'd0;
      vuelto    <= 12'd0;
      cnt       <= 8'd0;
      suma100_q <= 1'b0;
      suma500_q <= 1'b0;
      enable_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      credito   <= credito_nxt;
      vuelto    <= vuelto_nxt;
      cnt       <= cnt_nxt;
      suma100_q <= suma100;
      suma500_q <= suma500;
      enable_q  <= enable;
    end
  end

  // Decoded from the state register only, so reset drops them at once.
  assign valvula_agua = (state == AGUA);
  assign mezclador    = (state == MEZCLA);
  assign servir       = (state == SERVIR);
  assign listo        = (state == DONE);
  assign rechazo      = (state == DENY);
  assign estado       = state;

endmodule

// File: tb/tb_dispensador_bebidas.sv
// Directed testbench for dispensador_bebidas with T_ETAPA=4, CREDITO_MAX=2000.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_dispensador_bebidas;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        suma100, suma500, enable;
  logic [2:0]  sel;
  logic [11:0] credito, vuelto;
  logic        valvula_agua, mezclador, servir, listo, rechazo;
  logic [2:0]  estado;

  int n_checks = 0;
  int n_fail   = 0;

  dispensador_bebidas #(.T_ETAPA(T), .CREDITO_MAX(2000)) dut (
    .clk          (clk),
    .rst          (rst),
    .suma100      (suma100),
    .suma500      (suma500),
    .enable       (enable),
    .sel          (sel),
    .credito      (credito),
    .vuelto       (vuelto),
    .valvula_agua (valvula_agua),
    .mezclador    (mezclador),
    .servir       (servir),
    .listo        (listo),
    .rechazo      (rechazo),
    .estado       (estado)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs follow from the state the bench expects to be in.
  task automatic check_outs(input string tag, input int st);
    check_eq({tag, " estado"},       32'(estado),       32'(st));
    check_eq({tag, " valvula_agua"}, 32'(valvula_agua), 32'(st == 2));
    check_eq({tag, " mezclador"},    32'(mezclador),    32'(st == 3));
    check_eq({tag, " servir"},       32'(servir),       32'(st == 4));
    check_eq({tag, " listo"},        32'(listo),        32'(st == 5));
    check_eq({tag, " rechazo"},      32'(rechazo),      32'(st == 6));
  endtask

  task automatic coin(input logic c100, input logic c500, input int exp_cred);
    suma100 = c100;
    suma500 = c500;
    tick();
    check_eq("coin credito", 32'(credito), 32'(exp_cred));
    suma100 = 1'b0;
    suma500 = 1'b0;
    tick();
  endtask

  // inject[0]: second enable edge during AGUA; inject[1]: coin edge during SERVIR.
  task automatic sale(input logic [2:0] sel_v, input int exp_cred, input logic [1:0] inject);
    sel    = sel_v;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check_outs("sale check", 1);
    for (int s = 2; s <= 4; s++) begin
      for (int i = 0; i < T; i++) begin
        if (inject[0] && s == 2 && i == 1) enable = 1'b1;
        if (inject[1] && s == 4 && i == 1) suma100 = 1'b1;
        tick();
        enable  = 1'b0;
        suma100 = 1'b0;
        check_outs("sale stage", s);
        if (s == 2 && i == 0) begin
          check_eq("sale credito after check", 32'(credito), 32'(exp_cred));
          sel = 3'b111;
        end
        if (inject[1] && s == 4 && i == 1)
          check_eq("coin in servir ignored", 32'(credito), 32'(exp_cred));
      end
    end
    tick();
    check_outs("sale done", 5);
    tick();
    check_outs("sale idle", 0);
    check_eq("sale credito end", 32'(credito), 32'd0);
    check_eq("sale vuelto", 32'(vuelto), 32'(exp_cred));
  endtask

  task automatic deny(input logic [2:0] sel_v, input int exp_cred);
    sel    = sel_v;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check_outs("deny check", 1);
    tick();
    check_outs("deny pulse", 6);
    check_eq("deny credito", 32'(credito), 32'(exp_cred));
    tick();
    check_outs("deny idle", 0);
    check_eq("deny credito after", 32'(credito), 32'(exp_cred));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    suma100 = 1'b0;
    suma500 = 1'b0;
    enable  = 1'b0;
    sel     = 3'b000;
    repeat (2) tick();
    check_outs("reset", 0);
    check_eq("reset credito", 32'(credito), 32'd0);
    check_eq("reset vuelto",  32'(vuelto),  32'd0);
    rst = 1'b0;

    // 3 x 100, drink 001 costs 300, no change
    coin(1'b1, 1'b0, 100);
    coin(1'b1, 1'b0, 200);
    coin(1'b1, 1'b0, 300);
    sale(3'b001, 0, 2'b00);

    // 2 x 500, drink 010 costs 200, change 800
    coin(1'b0, 1'b1, 500);
    coin(1'b0, 1'b1, 1000);
    sale(3'b010, 800, 2'b00);

    // first coin after a sale clears vuelto; 200 < 500 is denied
    coin(1'b1, 1'b0, 100);
    check_eq("vuelto cleared by coin", 32'(vuelto), 32'd0);
    coin(1'b1, 1'b0, 200);
    deny(3'b011, 200);

    // invalid code with plenty of credit is denied
    coin(1'b0, 1'b1, 700);
    coin(1'b1, 1'b0, 800);
    coin(1'b1, 1'b0, 900);
    coin(1'b1, 1'b0, 1000);
    deny(3'b111, 1000);

    // exact credit 700 for drink 100 is accepted
    do_reset();
    check_eq("reset clears credito", 32'(credito), 32'd0);
    coin(1'b0, 1'b1, 500);
    coin(1'b1, 1'b0, 600);
    coin(1'b1, 1'b0, 700);
    sale(3'b100, 0, 2'b00);

    // saturation at 2000
    coin(1'b0, 1'b1, 500);
    coin(1'b0, 1'b1, 1000);
    coin(1'b0, 1'b1, 1500);
    coin(1'b0, 1'b1, 2000);
    coin(1'b0, 1'b1, 2000);

    // both levels already high at reset release: one cycle, +600
    rst     = 1'b1;
    suma100 = 1'b1;
    suma500 = 1'b1;
    tick();
    check_eq("held reset credito", 32'(credito), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("simultaneous coins", 32'(credito), 32'd600);
    suma100 = 1'b0;
    suma500 = 1'b0;
    tick();
    check_eq("no re-add when levels drop", 32'(credito), 32'd600);

    // reset in the middle of MEZCLA aborts at once
    sel    = 3'b001;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (T + 1) tick();
    check_outs("pre-abort", 3);
    check_eq("pre-abort credito", 32'(credito), 32'd300);
    #3;
    rst = 1'b1;
    #1;
    check_eq("abort mezclador", 32'(mezclador), 32'd0);
    check_eq("abort credito",   32'(credito),   32'd0);
    check_eq("abort estado",    32'(estado),    32'd0);
    tick();
    rst = 1'b0;

    // second enable in AGUA and coin in SERVIR are both ignored
    coin(1'b0, 1'b1, 500);
    sale(3'b001, 200, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
